// File: rtl/calc_key_if.sv
// rtl/calc_key_if.sv - key event and LCD handshake bundle for the calculator key sequencer
interface calc_key_if #(
    parameter int WIDTH = 27
) ();
    logic [9:0]       key_dig;
    logic             key_add;
    logic             key_eq;
    logic             key_clr;
    logic [WIDTH-1:0] disp_value;
    logic             disp_req;
    logic             disp_ack;
    logic [2:0]       state;
    logic             ovf;

    modport master (
        output key_dig, key_add, key_eq, key_clr, disp_ack,
        input  disp_value, disp_req, state, ovf
    );

    modport slave (
        input  key_dig, key_add, key_eq, key_clr, disp_ack,
        output disp_value, disp_req, state, ovf
    );
endinterface

// File: rtl/calc_key_sequencer.sv
// rtl/calc_key_sequencer.sv - decimal entry / add / equals sequencer with LCD req/ack updates
module calc_key_sequencer #(
    parameter int WIDTH      = 27,
    parameter int MAX_DIGITS = 8
) (
    input logic       clk,
    input logic       rst,
    calc_key_if.slave bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        OPWAIT = 3'd2,
        RESULT = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] operand_q, operand_n;
    logic [WIDTH-1:0] acc_q, acc_n;
    logic [WIDTH-1:0] disp_q, disp_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             ovf_q, ovf_n;
    logic             req_q, req_n;
    logic [12:0]      keys_now, hist_q, edges;
    logic [9:0]       dig_edge;
    logic             dig_ev, add_ev, eq_ev, clr_ev;
    logic [3:0]       dig_val;
    logic [WIDTH-1:0] dig_word;
    logic [WIDTH+3:0] op_dig;
    logic [WIDTH:0]   sum;
    logic             dig_fits, sum_fits;

    assign keys_now = {bus.key_clr, bus.key_eq, bus.key_add, bus.key_dig};
    assign edges    = keys_now & ~hist_q;
    assign dig_edge = edges[9:0];
    // Simultaneous digit edges are ambiguous, so only a single digit edge counts.
    assign dig_ev   = $onehot(dig_edge);
    assign add_ev   = edges[10];
    assign eq_ev    = edges[11];
    assign clr_ev   = edges[12];

    always_comb begin
        dig_val = '0;
        for (int i = 0; i < 10; i++) begin
            if (dig_edge[i]) dig_val = 4'(i);
        end
    end

    assign dig_word = {{(WIDTH-4){1'b0}}, dig_val};
    assign op_dig   = ({4'b0, operand_q} << 3) + ({4'b0, operand_q} << 1) + {4'b0, dig_word};
    assign dig_fits = (op_dig[WIDTH+3:WIDTH] == 4'd0);
    assign sum      = {1'b0, acc_q} + {1'b0, operand_q};
    assign sum_fits = !sum[WIDTH];

    always_comb begin
        state_n   = state_q;
        operand_n = operand_q;
        acc_n     = acc_q;
        cnt_n     = cnt_q;
        ovf_n     = ovf_q;
        if (clr_ev) begin
            state_n   = IDLE;
            operand_n = '0;
            acc_n     = '0;
            cnt_n     = '0;
            ovf_n     = 1'b0;
        end else begin
            case (state_q)
                IDLE, OPWAIT: begin
                    if (eq_ev) begin
                        if (state_q == OPWAIT) state_n = RESULT;
                    end else if (!add_ev && dig_ev) begin
                        operand_n = dig_word;
                        cnt_n     = CW'(1);
                        state_n   = ENTRY;
                    end
                end
                ENTRY: begin
                    if (eq_ev || add_ev) begin
                        if (sum_fits) begin
                            acc_n     = sum[WIDTH-1:0];
                            operand_n = '0;
                            cnt_n     = '0;
                            state_n   = eq_ev ? RESULT : OPWAIT;
                        end else begin
                            state_n = ERROR;
                            ovf_n   = 1'b1;
                        end
                    end else if (dig_ev && cnt_q < CW'(MAX_DIGITS)) begin
                        if (dig_fits) begin
                            operand_n = op_dig[WIDTH-1:0];
                            cnt_n     = cnt_q + CW'(1);
                        end else begin
                            state_n = ERROR;
                            ovf_n   = 1'b1;
                        end
                    end
                end
                RESULT: begin
                    if (eq_ev) begin
                        state_n = RESULT;
                    end else if (add_ev) begin
                        state_n = OPWAIT;
                    end else if (dig_ev) begin
                        acc_n     = '0;
                        operand_n = dig_word;
                        cnt_n     = CW'(1);
                        state_n   = ENTRY;
                    end
                end
                ERROR:   state_n = ERROR;
                default: state_n = IDLE;
            endcase
        end

        case (state_n)
            ENTRY:          disp_n = operand_n;
            OPWAIT, RESULT: disp_n = acc_n;
            ERROR:          disp_n = '1;
            default:        disp_n = '0;
        endcase

        // A fresh update in the same cycle as disp_ack keeps the request pending.
        if (clr_ev || disp_n != disp_q) req_n = 1'b1;
        else if (bus.disp_ack)          req_n = 1'b0;
        else                            req_n = req_q;
    end

    always_ff @(posedge clk) begin
        hist_q <= keys_now;
        if (rst) begin
            state_q   <= IDLE;
            operand_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            disp_q    <= '0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            operand_q <= operand_n;
            acc_q     <= acc_n;
            cnt_q     <= cnt_n;
            ovf_q     <= ovf_n;
            disp_q    <= disp_n;
            req_q     <= req_n;
        end
    end

    assign bus.disp_value = disp_q;
    assign bus.disp_req   = req_q;
    assign bus.state      = state_q;
    assign bus.ovf        = ovf_q;
endmodule
